// File: rtl/branch_resolve_predict_if.sv
// Bundle of fetch-side prediction and EX-side resolution signals for
// branch_resolve_predict. "slave" is the branch unit's view, "master" is the
// pipeline's view.
interface branch_resolve_predict_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] fetch_pc;
   logic            pred_taken;
   logic            ex_valid;
   logic            ex_branch;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_pc;
   logic            ex_pred_taken;
   logic            equal_out;
   logic            slt_out;
   logic            sltu_out;
   logic            resolve_valid;
   logic            branch_taken;
   logic            mispredict;
   logic            illegal_cond;

   modport master (
      output fetch_pc, ex_valid, ex_branch, ex_funct3, ex_pc, ex_pred_taken,
             equal_out, slt_out, sltu_out,
      input  pred_taken, resolve_valid, branch_taken, mispredict, illegal_cond
   );

   modport slave (
      input  fetch_pc, ex_valid, ex_branch, ex_funct3, ex_pc, ex_pred_taken,
             equal_out, slt_out, sltu_out,
      output pred_taken, resolve_valid, branch_taken, mispredict, illegal_cond
   );
endinterface

// File: rtl/branch_resolve_predict.sv
// Branch resolution and direct-mapped BHT predictor.
// Resolves conditional branches from EX comparator results, registers the
// outcome (one-cycle mispredict pulse) and trains a table of saturating
// counters indexed by pc[IDX_W+1:2]. fetch_pc reads the table combinationally.
// Optional macro BHT_BYPASS_EN: forward the post-update counter to
// pred_taken when fetch and EX hit the same entry in the same cycle.
module branch_resolve_predict #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int CTR_BITS    = 2
) (
   input logic                    clk,
   input logic                    rst,
   branch_resolve_predict_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

   logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

   logic [IDX_W-1:0]    fetch_idx;
   logic [IDX_W-1:0]    ex_idx;
   logic                resolve;
   logic                cond_taken;
   logic                cond_legal;
   logic                train;
   logic [CTR_BITS-1:0] ex_ctr;
   logic [CTR_BITS-1:0] ctr_next;
   logic                unused_pc_bits;

   assign fetch_idx = bus.fetch_pc[IDX_W+1:2];
   assign ex_idx    = bus.ex_pc[IDX_W+1:2];
   assign resolve   = bus.ex_valid & bus.ex_branch;
   assign train     = resolve & cond_legal;
   assign ex_ctr    = bht[ex_idx];

   // PC bits outside the index field alias by design
   assign unused_pc_bits = ^{bus.fetch_pc[XLEN-1:IDX_W+2], bus.fetch_pc[1:0],
                             bus.ex_pc[XLEN-1:IDX_W+2], bus.ex_pc[1:0]};

   // Evaluate the branch condition selected by funct3
   always_comb begin
      cond_taken = 1'b0;
      cond_legal = 1'b1;
      case (bus.ex_funct3)
         3'b000:  cond_taken = bus.equal_out;
         3'b001:  cond_taken = ~bus.equal_out;
         3'b100:  cond_taken = bus.slt_out;
         3'b101:  cond_taken = ~bus.slt_out;
         3'b110:  cond_taken = bus.sltu_out;
         3'b111:  cond_taken = ~bus.sltu_out;
         default: cond_legal = 1'b0;
      endcase
   end

   // Saturating counter step for the EX entry
   always_comb begin
      ctr_next = ex_ctr;
      if (cond_taken) begin
         if (ex_ctr != CTR_MAX) ctr_next = ex_ctr + CTR_ONE;
      end else begin
         if (ex_ctr != '0) ctr_next = ex_ctr - CTR_ONE;
      end
   end

   // Prediction read for the fetch PC
   always_comb begin
`ifdef BHT_BYPASS_EN
      if (train && (fetch_idx == ex_idx))
         bus.pred_taken = ctr_next[CTR_BITS-1];
      else
         bus.pred_taken = bht[fetch_idx][CTR_BITS-1];
`else
      bus.pred_taken = bht[fetch_idx][CTR_BITS-1];
`endif
   end

   // Register resolution outputs and train the table; reset wins over a resolve
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[IDX_W'(i)] <= CTR_WNT;
         bus.resolve_valid <= 1'b0;
         bus.branch_taken  <= 1'b0;
         bus.mispredict    <= 1'b0;
         bus.illegal_cond  <= 1'b0;
      end else begin
         bus.resolve_valid <= resolve;
         bus.branch_taken  <= resolve & cond_taken;
         bus.mispredict    <= resolve & (cond_taken != bus.ex_pred_taken);
         bus.illegal_cond  <= resolve & ~cond_legal;
         if (train) bht[ex_idx] <= ctr_next;
      end
   end
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed, table-driven bench for branch_resolve_predict (default parameters).
module tb_branch_resolve_predict;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   branch_resolve_predict_if #(.XLEN(XLEN)) bus ();

   branch_resolve_predict #(
      .XLEN(XLEN),
      .BHT_ENTRIES(64),
      .CTR_BITS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] fpc;
      logic        v;
      logic        b;
      logic [2:0]  f3;
      logic [31:0] epc;
      logic        ep;
      logic        eq;
      logic        slt;
      logic        sltu;
      logic        x_pred;
      logic        x_rv;
      logic        x_bt;
      logic        x_mp;
      logic        x_ill;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic r, logic [31:0] fpc, logic v, logic b,
                               logic [2:0] f3, logic [31:0] epc, logic ep, logic eq,
                               logic slt, logic sltu, logic xp, logic xrv, logic xbt,
                               logic xmp, logic xill);
      vec_t t;
      t.name = name; t.rst = r; t.fpc = fpc; t.v = v; t.b = b; t.f3 = f3; t.epc = epc;
      t.ep = ep; t.eq = eq; t.slt = slt; t.sltu = sltu; t.x_pred = xp; t.x_rv = xrv;
      t.x_bt = xbt; t.x_mp = xmp; t.x_ill = xill;
      return t;
   endfunction

   task automatic check(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(vec_t t);
      rst               = t.rst;
      bus.fetch_pc      = t.fpc;
      bus.ex_valid      = t.v;
      bus.ex_branch     = t.b;
      bus.ex_funct3     = t.f3;
      bus.ex_pc         = t.epc;
      bus.ex_pred_taken = t.ep;
      bus.equal_out     = t.eq;
      bus.slt_out       = t.slt;
      bus.sltu_out      = t.sltu;
   endtask

   task automatic check_regs(string name, logic rv, logic bt, logic mp, logic ill);
      check({name, ".resolve_valid"}, bus.resolve_valid, rv);
      check({name, ".branch_taken"},  bus.branch_taken,  bt);
      check({name, ".mispredict"},    bus.mispredict,    mp);
      check({name, ".illegal_cond"},  bus.illegal_cond,  ill);
   endtask

   initial begin
      logic exp_bypass;
      // name rst fetch v b f3 ex_pc ep eq slt sltu | pred rv bt mp ill
      vecs.push_back(mk("idle40",   0, 32'h40, 0,0,3'b000, 32'h0,  0,0,0,0, 0, 0,0,0,0));
      vecs.push_back(mk("beq40",    0, 32'h80, 1,1,3'b000, 32'h40, 0,1,0,0, 0, 1,1,1,0));
      vecs.push_back(mk("pred40",   0, 32'h40, 0,0,3'b000, 32'h0,  0,0,0,0, 1, 0,0,0,0));
      vecs.push_back(mk("bltu80a",  0, 32'h40, 1,1,3'b110, 32'h80, 0,0,0,1, 1, 1,1,1,0));
      vecs.push_back(mk("bltu80b",  0, 32'h40, 1,1,3'b110, 32'h80, 1,0,0,1, 1, 1,1,0,0));
      vecs.push_back(mk("bltu80c",  0, 32'h40, 1,1,3'b110, 32'h80, 1,0,0,1, 1, 1,1,0,0));
      vecs.push_back(mk("bgeu80",   0, 32'h40, 1,1,3'b111, 32'h80, 1,0,0,1, 1, 1,0,1,0));
      vecs.push_back(mk("pred80",   0, 32'h80, 0,0,3'b000, 32'h0,  0,0,0,0, 1, 0,0,0,0));
      vecs.push_back(mk("ill010",   0, 32'h40, 1,1,3'b010, 32'h80, 1,0,1,1, 1, 1,0,1,1));
      vecs.push_back(mk("ill011",   0, 32'h40, 1,1,3'b011, 32'h80, 0,1,0,0, 1, 1,0,0,1));
      vecs.push_back(mk("post_ill", 0, 32'h80, 0,0,3'b000, 32'h0,  0,0,0,0, 1, 0,0,0,0));
      vecs.push_back(mk("nobranch", 0, 32'h80, 1,0,3'b000, 32'h80, 1,0,0,0, 1, 0,0,0,0));
      vecs.push_back(mk("novalid",  0, 32'h80, 0,1,3'b000, 32'h80, 1,0,0,0, 1, 0,0,0,0));
      vecs.push_back(mk("post_nop", 0, 32'h80, 0,0,3'b000, 32'h0,  0,0,0,0, 1, 0,0,0,0));
      vecs.push_back(mk("bneC0",    0, 32'h80, 1,1,3'b001, 32'hC0, 1,0,0,0, 1, 1,1,0,0));
      vecs.push_back(mk("bltC0",    0, 32'hC0, 1,1,3'b100, 32'hC0, 1,0,1,0, 1, 1,1,0,0));
      vecs.push_back(mk("bgeC0",    0, 32'h40, 1,1,3'b101, 32'hC0, 1,0,1,0, 1, 1,0,1,0));
      vecs.push_back(mk("bge44",    0, 32'hC0, 1,1,3'b101, 32'h44, 0,0,0,0, 1, 1,1,1,0));
      vecs.push_back(mk("beq40nt",  0, 32'h44, 1,1,3'b000, 32'h40, 1,0,0,0, 1, 1,0,1,0));
      vecs.push_back(mk("pred40b",  0, 32'h40, 0,0,3'b000, 32'h0,  0,0,0,0, 0, 0,0,0,0));
      vecs.push_back(mk("bltC0nt",  0, 32'h80, 1,1,3'b100, 32'hC0, 0,0,0,0, 1, 1,0,0,0));
      vecs.push_back(mk("beq100",   0, 32'hC0, 1,1,3'b000, 32'h100,1,1,0,0, 0, 1,1,0,0));
      vecs.push_back(mk("rst_res",  1, 32'h80, 1,1,3'b000, 32'h80, 0,1,0,0, 1, 0,0,0,0));
      vecs.push_back(mk("post_r80", 0, 32'h80, 0,0,3'b000, 32'h0,  0,0,0,0, 0, 0,0,0,0));
      vecs.push_back(mk("post_r44", 0, 32'h44, 0,0,3'b000, 32'h0,  0,0,0,0, 0, 0,0,0,0));
      vecs.push_back(mk("post_r100",0, 32'h100,0,0,3'b000, 32'h0,  0,0,0,0, 0, 0,0,0,0));

      // Initial reset
      drive(mk("init", 1, 32'h0, 0,0,3'b000, 32'h0, 0,0,0,0, 0,0,0,0,0));
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset", 1'b0, 1'b0, 1'b0, 1'b0);

      // Table: pred_taken checked before the edge, registered outputs after it
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check({vecs[i].name, ".pred_taken"}, bus.pred_taken, vecs[i].x_pred);
         @(posedge clk);
         #1;
         check_regs(vecs[i].name, vecs[i].x_rv, vecs[i].x_bt, vecs[i].x_mp, vecs[i].x_ill);
      end

      // Every entry reads weakly-not-taken after the mid-run reset; upper and
      // low PC bits must not affect the index
      @(negedge clk);
      drive(mk("idle", 0, 32'h0, 0,0,3'b000, 32'h0, 0,0,0,0, 0,0,0,0,0));
      for (int i = 0; i < 64; i++) begin
         bus.fetch_pc = 32'hA500_0000 | (32'(i) << 2) | 32'h3;
         #1;
         check($sformatf("entry%0d_rst", i), bus.pred_taken, 1'b0);
      end

      // Same-cycle fetch and taken resolution on entry 0x100 (counter 01)
`ifdef BHT_BYPASS_EN
      exp_bypass = 1'b1;
`else
      exp_bypass = 1'b0;
`endif
      @(negedge clk);
      drive(mk("same", 0, 32'h100, 1,1,3'b000, 32'h100, 0,1,0,0, 0,0,0,0,0));
      #1;
      check("same_cycle.pred_taken", bus.pred_taken, exp_bypass);
      @(posedge clk);
      #1;
      check_regs("same_cycle", 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      drive(mk("after", 0, 32'h100, 0,0,3'b000, 32'h0, 0,0,0,0, 0,0,0,0,0));
      #1;
      check("after_same.pred_taken", bus.pred_taken, 1'b1);
      @(posedge clk);
      #1;
      check_regs("after_same", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/branch_resolve_predict.md
Name: branch_resolve_predict

Overview:
- Parametrised next-generation branch unit: resolves conditional branches from EX-stage comparator results and trains a direct-mapped branch history table (BHT) of saturating counters.
- The BHT supplies taken/not-taken predictions to fetch.
- Resolution is registered, so the unit delivers a one-cycle `mispredict` pulse for the pipeline flush logic.
- Sits between the EX-stage comparators and the IF-stage next-PC mux.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of BHT entries; power of two, minimum 2.
- CTR_BITS, 2, width of each saturating counter; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fetch_pc  in  XLEN  PC of instruction being fetched.
- pred_taken  out  1  combinational prediction for fetch_pc.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_funct3  in  3  branch condition, instruction[14:12].
- ex_pc  in  XLEN  PC of EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction.
- equal_out  in  1  rs1==rs2.
- slt_out  in  1  signed rs1<rs2.
- sltu_out  in  1  unsigned rs1<rs2.
- resolve_valid  out  1  registered; a branch was resolved last cycle.
- branch_taken  out  1  registered resolved direction.
- mispredict  out  1  registered one-cycle pulse.
- illegal_cond  out  1  registered; funct3 was 010 or 011.

Behaviour:
- IDX_W = log2(BHT_ENTRIES).
- Index = pc[IDX_W+1:2]. The two LSBs are ignored.
- BHT is implemented as flops so the whole table can be reset in one cycle.
- pred_taken = MSB of BHT[index(fetch_pc)]. Purely combinational, zero latency.
- Resolve event R = ex_valid & ex_branch. Condition `t` is evaluated in the same cycle:
  - 000 BEQ: t = equal_out.
  - 001 BNE: t = ~equal_out.
  - 100 BLT: t = slt_out.
  - 101 BGE: t = ~slt_out.
  - 110 BLTU: t = sltu_out.
  - 111 BGEU: t = ~sltu_out.
  - 010 and 011: t = 0 and the illegal flag is set.
- Registered outputs, latency 1 cycle:
  - Cycle after R: resolve_valid=1, branch_taken=t, mispredict=(t != ex_pred_taken), illegal_cond=(funct3 is 010/011).
  - Cycle after R=0: all four outputs are 0. mispredict is never held longer than one cycle.
- BHT training, at the same clock edge as output registration, when R=1 and funct3 is legal:
  - t=1: counter increments, saturating at 2^CTR_BITS-1.
  - t=0: counter decrements, saturating at 0.
  - Illegal funct3: no update.
- Back-to-back resolutions on consecutive cycles are fully supported: one update per cycle, no stall.
- A resolution to the same index on consecutive cycles sees the already-updated value. Example: 2 taken resolutions from 00 give 10.
- Simultaneous fetch read and EX update to the same index, macro off: pred_taken reflects the pre-update value.
- Reset:
  - Every counter is set to weakly-not-taken, 2^(CTR_BITS-1)-1 (01 for 2 bits; 0 for CTR_BITS=1).
  - resolve_valid, branch_taken, mispredict and illegal_cond are set to 0.
  - rst has priority over R. Asserting rst in the cycle of a resolution discards it: no update, no output pulse next cycle.
- ex_pc and fetch_pc above XLEN-1 do not exist. PCs differing only above bit IDX_W+1 alias to the same entry, by design.

Optional Feature:
- Macro: BHT_BYPASS_EN.
- Defined: when R=1 with legal funct3 and index(fetch_pc)==index(ex_pc) in the same cycle, pred_taken is the MSB of the post-update counter value (write-through bypass).
- Not defined: pred_taken always reads stored table state; no forwarding path.
- Registered outputs and training are identical in both builds.

Test Plan:
- Reset, then fetch_pc=0x0000_0040 -> pred_taken=0. rst=1 for one cycle mid-run -> all outputs 0 next cycle and every entry reads 01.
- BEQ at ex_pc=0x40, equal_out=1, ex_pred_taken=0 -> next cycle resolve_valid=1, branch_taken=1, mispredict=1. The entry becomes 10, so pred_taken for 0x40 becomes 1.
- Three taken BLTU (sltu_out=1) at 0x80 on consecutive cycles -> counter goes 01→10→11→11 (saturates). Then one BGEU with sltu_out=1 (not taken) -> 10, and pred_taken stays 1.
- funct3=010, ex_branch=1 -> next cycle illegal_cond=1, branch_taken=0, and the counter is unchanged.
- ex_valid=1, ex_branch=0 -> resolve_valid=0 and mispredict=0 next cycle; no table change. ex_branch=1 with rst=1 in the same cycle -> no pulse.
- Same-cycle fetch_pc=ex_pc=0x100 with a taken resolution from 01:
  - BHT_BYPASS_EN defined -> pred_taken=1 in that cycle.
  - Undefined -> pred_taken=0 in that cycle, then 1 on the following cycle.
